// File: rtl/coreaxi4dma_rd_tran_ctrl.sv
// coreaxi4dma_rd_tran_ctrl
// Consumer side of the two-entry read transaction queue. Pops the head request,
// splits it into AXI4 read bursts (INCR or FIXED), forwards R beats to the
// read data cache with back-pressure and retires the entry with a done/error
// pulse.
//
// Optional feature: define COREAXI4DMA_RD_RRESP_CHK_EN to make SLVERR/DECERR
// responses abort the request (remaining beats of the burst are drained and
// the entry retires with rdErr). Without it RRESP is ignored.
//
// Ports:
//   clock, resetn                 clock, asynchronous active-low reset
//   reqInQueue, srcAddr, srcOp,
//   numOfBytes, dataValid         head request from the transaction queue
//   rdCache1Sel                   queue read pointer / cache slot select
//   clrRdTranQueue, rdDone, rdErr retire pulse and completion status
//   ARID..ARREADY                 AXI4 read address channel
//   RDATA..RREADY                 AXI4 read data channel
//   cacheWrData, cacheWrEn,
//   cacheReady                    read data cache write port
module coreaxi4dma_rd_tran_ctrl #(
  parameter int AXI_DATA_WIDTH      = 64,
  parameter int MAX_TRAN_SIZE_WIDTH = 23,
  parameter int MAX_BURST_BEATS     = 16,
  parameter int ID_WIDTH            = 1
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           reqInQueue,
  input  logic [31:0]                    srcAddr,
  input  logic [1:0]                     srcOp,
  input  logic [MAX_TRAN_SIZE_WIDTH-1:0] numOfBytes,
  input  logic                           dataValid,
  output logic                           rdCache1Sel,
  output logic [1:0]                     clrRdTranQueue,
  output logic                           rdDone,
  output logic                           rdErr,
  output logic [ID_WIDTH-1:0]            ARID,
  output logic [31:0]                    ARADDR,
  output logic [7:0]                     ARLEN,
  output logic [2:0]                     ARSIZE,
  output logic [1:0]                     ARBURST,
  output logic                           ARVALID,
  input  logic                           ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0]      RDATA,
  input  logic [1:0]                     RRESP,
  input  logic                           RLAST,
  input  logic                           RVALID,
  output logic                           RREADY,
  output logic [AXI_DATA_WIDTH-1:0]      cacheWrData,
  output logic                           cacheWrEn,
  input  logic                           cacheReady
);

  localparam int BPB = AXI_DATA_WIDTH / 8;
  localparam int SZ  = $clog2(BPB);
  localparam int RW  = MAX_TRAN_SIZE_WIDTH;
  // Common width for the burst-length minimum; must hold the 4 KB beat count.
  localparam int MW  = (RW > 13) ? RW : 13;
  localparam logic [RW:0] BPB_M1 = (RW+1)'(BPB - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_RETIRE = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [RW-1:0] remain_q, remain_d;
  logic [1:0]    op_q, op_d;
  logic [8:0]    burst_q, burst_d;
  logic          err_q, err_d;
  logic          drain_q, drain_d;
  logic          sel_q, sel_d;

  logic [RW:0]   bytes_rnd;
  logic [RW-1:0] req_beats;
  logic [12:0]   to_bound;
  logic [MW-1:0] rem_w, cap_w, len_w;
  logic [8:0]    burst_len;
  logic          r_acc;
  logic          resp_bad;
  logic          unused_bits;

  // ceil(numOfBytes / BPB); one extra bit absorbs the rounding carry.
  assign bytes_rnd = {1'b0, numOfBytes} + BPB_M1;
  assign req_beats = RW'(bytes_rnd >> SZ);

  // Beats left before the next 4 KB page (address is always beat aligned).
  assign to_bound = (13'h1000 - {1'b0, addr_q[11:0]}) >> SZ;

  always_comb begin
    rem_w = MW'(remain_q);
    if (op_q == 2'b10) begin
      cap_w = MW'(16);
    end else begin
      cap_w = MW'(MAX_BURST_BEATS);
      if (MW'(to_bound) < cap_w) cap_w = MW'(to_bound);
    end
    len_w = (rem_w < cap_w) ? rem_w : cap_w;
  end
  assign burst_len = 9'(len_w);

`ifdef COREAXI4DMA_RD_RRESP_CHK_EN
  assign resp_bad = RRESP[1];  // SLVERR (10) or DECERR (11)
`else
  assign resp_bad = 1'b0;
`endif

  assign unused_bits = ^{srcAddr[SZ-1:0], RRESP};

  // While draining after an error, beats are swallowed regardless of the cache.
  assign RREADY    = (state_q == S_DATA) & (drain_q | cacheReady);
  assign r_acc     = RVALID & RREADY;
  assign cacheWrEn = r_acc & ~drain_q;
  assign cacheWrData = RDATA;

  assign ARID    = '0;
  assign ARADDR  = addr_q;
  assign ARLEN   = (state_q == S_ADDR) ? 8'(burst_len - 9'd1) : 8'd0;
  assign ARSIZE  = 3'(SZ);
  assign ARBURST = (op_q == 2'b01) ? 2'b01 : 2'b00;
  assign ARVALID = (state_q == S_ADDR);

  assign clrRdTranQueue = (state_q == S_RETIRE) ? 2'b01 : 2'b00;
  assign rdDone         = (state_q == S_RETIRE) & ~err_q;
  assign rdErr          = (state_q == S_RETIRE) & err_q;
  assign rdCache1Sel    = sel_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    op_d     = op_q;
    burst_d  = burst_q;
    err_d    = err_q;
    drain_d  = drain_q;
    sel_d    = sel_q;
    case (state_q)
      S_IDLE: begin
        if (reqInQueue) state_d = S_LOAD;
      end
      S_LOAD: begin
        addr_d   = {srcAddr[31:SZ], {SZ{1'b0}}};
        remain_d = req_beats;
        op_d     = srcOp;
        err_d    = 1'b0;
        drain_d  = 1'b0;
        if (!dataValid || (srcOp == 2'b00) || (numOfBytes == '0)) begin
          state_d = S_RETIRE;
        end else if (srcOp == 2'b11) begin
          err_d   = 1'b1;
          state_d = S_RETIRE;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (ARREADY) begin
          burst_d = burst_len;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (r_acc) begin
          // Saturate so an over-long burst cannot wrap the beat counter.
          if (remain_q != '0) remain_d = remain_q - 1'b1;
          if (resp_bad) err_d = 1'b1;
          if (RLAST) begin
            // A short burst simply ends early; the remaining count already
            // reflects only the beats that actually arrived.
            drain_d = 1'b0;
            if ((remain_d == '0) || err_d) begin
              state_d = S_RETIRE;
            end else begin
              if (op_q == 2'b01) addr_d = addr_q + (32'(burst_q) << SZ);
              state_d = S_ADDR;
            end
          end else if (resp_bad) begin
            drain_d = 1'b1;
          end
        end
      end
      S_RETIRE: begin
        sel_d   = ~sel_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      op_q     <= 2'b00;
      burst_q  <= '0;
      err_q    <= 1'b0;
      drain_q  <= 1'b0;
      sel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      op_q     <= op_d;
      burst_q  <= burst_d;
      err_q    <= err_d;
      drain_q  <= drain_d;
      sel_q    <= sel_d;
    end
  end

endmodule

// File: tb/tb_coreaxi4dma_rd_tran_ctrl.sv
// Directed testbench for coreaxi4dma_rd_tran_ctrl (default parameters, BPB=8).
// A simple AXI read slave answers every AR with ARLEN+1 beats of incrementing
// data; a monitor records AR requests, cache writes and retire pulses.
module tb_coreaxi4dma_rd_tran_ctrl;

  logic        clock = 1'b0;
  logic        resetn;
  logic        reqInQueue;
  logic [31:0] srcAddr;
  logic [1:0]  srcOp;
  logic [22:0] numOfBytes;
  logic        dataValid;
  logic        rdCache1Sel;
  logic [1:0]  clrRdTranQueue;
  logic        rdDone, rdErr;
  logic [0:0]  ARID;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID, ARREADY;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST, RVALID, RREADY;
  logic [63:0] cacheWrData;
  logic        cacheWrEn;
  logic        cacheReady;

  coreaxi4dma_rd_tran_ctrl dut (
    .clock(clock), .resetn(resetn), .reqInQueue(reqInQueue), .srcAddr(srcAddr),
    .srcOp(srcOp), .numOfBytes(numOfBytes), .dataValid(dataValid),
    .rdCache1Sel(rdCache1Sel), .clrRdTranQueue(clrRdTranQueue), .rdDone(rdDone),
    .rdErr(rdErr), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY), .RDATA(RDATA),
    .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .cacheWrData(cacheWrData), .cacheWrEn(cacheWrEn), .cacheReady(cacheReady)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Owned by the slave
  logic [63:0] data_ctr;
  int          beat_no;
  // Owned by the main sequence
  int          err_beat;
  logic        toggle_en;
  logic        exp_sel;
  // Owned by the monitor
  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];
  logic [1:0]  ar_burst_q[$];
  logic [63:0] wr_q[$];
  int          done_cnt = 0, err_cnt = 0, clr_cnt = 0, drain_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // AXI read slave: inputs change 1 time unit after the rising edge.
  initial begin
    ARREADY  = 1'b1;
    RVALID   = 1'b0;
    RLAST    = 1'b0;
    RRESP    = 2'b00;
    data_ctr = 64'h1111_0000_0000_0000;
    beat_no  = 0;
    RDATA    = data_ctr;
    forever begin
      @(negedge clock);
      if (resetn && ARVALID && ARREADY) begin
        automatic int len = int'(ARLEN);
        @(posedge clock); #1;
        for (int b = 0; b <= len; b++) begin
          RVALID = 1'b1;
          RDATA  = data_ctr;
          RLAST  = (b == len);
          RRESP  = (beat_no == err_beat) ? 2'b10 : 2'b00;
          @(negedge clock);
          while (!RREADY) @(negedge clock);
          @(posedge clock); #1;
          data_ctr = data_ctr + 64'd1;
          beat_no  = beat_no + 1;
        end
        RVALID = 1'b0;
        RLAST  = 1'b0;
        RRESP  = 2'b00;
      end
    end
  end

  // cacheReady: steady high, or toggling every cycle while toggle_en is set.
  initial begin
    cacheReady = 1'b1;
    forever begin
      @(posedge clock); #1;
      cacheReady = toggle_en ? ~cacheReady : 1'b1;
    end
  end

  // Monitor: sampled on the falling edge, i.e. what the next rising edge sees.
  initial begin
    forever begin
      @(negedge clock);
      if (resetn) begin
        if (ARVALID && ARREADY) begin
          ar_addr_q.push_back(ARADDR);
          ar_len_q.push_back(ARLEN);
          ar_burst_q.push_back(ARBURST);
        end
        if (cacheWrEn) wr_q.push_back(cacheWrData);
        if (RVALID && RREADY && !cacheWrEn) drain_cnt++;
        if (rdDone) done_cnt++;
        if (rdErr) err_cnt++;
        if (clrRdTranQueue == 2'b01) clr_cnt++;
        if (toggle_en && RVALID) check("rready_follows_cacheReady", RREADY, cacheReady);
      end
    end
  end

  // Issue one request, wait (bounded) for its retire, then check the pointer.
  task automatic run_req(input string name, input logic [31:0] a, input logic [22:0] nb,
                         input logic [1:0] op, input logic dv, output int cyc);
    logic seen;
    @(posedge clock); #1;
    srcAddr    = a;
    numOfBytes = nb;
    srcOp      = op;
    dataValid  = dv;
    reqInQueue = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 3000 && !seen) begin
      @(negedge clock);
      cyc++;
      if (clrRdTranQueue === 2'b01) seen = 1'b1;
    end
    check({name, "_retire_seen"}, seen, 1'b1);
    @(posedge clock); #1;
    reqInQueue = 1'b0;
    @(negedge clock);
    exp_sel = ~exp_sel;
    check({name, "_rdCache1Sel"}, rdCache1Sel, exp_sel);
  endtask

  function automatic int order_errors(input int w0, input logic [63:0] base);
    int bad = 0;
    for (int i = w0; i < wr_q.size(); i++)
      if (wr_q[i] !== base + 64'(i - w0)) bad++;
    return bad;
  endfunction

  int          a0, w0, d0, e0, c0, r0, cyc;
  logic [63:0] base;

  initial begin
    resetn = 1'b0; reqInQueue = 1'b0; srcAddr = '0; srcOp = 2'b00;
    numOfBytes = '0; dataValid = 1'b0; err_beat = -1; toggle_en = 1'b0; exp_sel = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_ARVALID", ARVALID, 1'b0);
    check("reset_ARLEN", ARLEN, 8'd0);
    check("reset_ARADDR", ARADDR, 32'd0);
    check("reset_ARSIZE", ARSIZE, 3'd3);
    check("reset_RREADY", RREADY, 1'b0);
    check("reset_clr", clrRdTranQueue, 2'b00);
    check("reset_rdDone", rdDone, 1'b0);
    check("reset_rdErr", rdErr, 1'b0);
    check("reset_sel", rdCache1Sel, 1'b0);
    @(posedge clock); #1;
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // T1: 64 bytes INCR at 0x1000 -> single 8-beat burst
    a0 = ar_addr_q.size(); w0 = wr_q.size(); d0 = done_cnt; e0 = err_cnt; c0 = clr_cnt; base = data_ctr;
    run_req("t1", 32'h1000, 23'd64, 2'b01, 1'b1, cyc);
    check("t1_ar_count", ar_addr_q.size() - a0, 1);
    check("t1_araddr", ar_addr_q[a0], 32'h1000);
    check("t1_arlen", ar_len_q[a0], 8'd7);
    check("t1_arburst", ar_burst_q[a0], 2'b01);
    check("t1_beats", wr_q.size() - w0, 8);
    check("t1_order", order_errors(w0, base), 0);
    check("t1_done", done_cnt - d0, 1);
    check("t1_err", err_cnt - e0, 0);
    check("t1_clr", clr_cnt - c0, 1);

    // T2: 200 bytes -> 25 beats split 16 + 9
    a0 = ar_addr_q.size(); w0 = wr_q.size(); d0 = done_cnt; base = data_ctr;
    run_req("t2", 32'h2000, 23'd200, 2'b01, 1'b1, cyc);
    check("t2_ar_count", ar_addr_q.size() - a0, 2);
    check("t2_araddr0", ar_addr_q[a0], 32'h2000);
    check("t2_arlen0", ar_len_q[a0], 8'd15);
    check("t2_araddr1", ar_addr_q[a0+1], 32'h2080);
    check("t2_arlen1", ar_len_q[a0+1], 8'd8);
    check("t2_beats", wr_q.size() - w0, 25);
    check("t2_order", order_errors(w0, base), 0);
    check("t2_done", done_cnt - d0, 1);

    // T3: 4 KB boundary at 0xFF8 -> 1 + 3 beats
    a0 = ar_addr_q.size(); w0 = wr_q.size(); base = data_ctr;
    run_req("t3", 32'h0FF8, 23'd32, 2'b01, 1'b1, cyc);
    check("t3_ar_count", ar_addr_q.size() - a0, 2);
    check("t3_araddr0", ar_addr_q[a0], 32'h0FF8);
    check("t3_arlen0", ar_len_q[a0], 8'd0);
    check("t3_araddr1", ar_addr_q[a0+1], 32'h1000);
    check("t3_arlen1", ar_len_q[a0+1], 8'd2);
    check("t3_order", order_errors(w0, base), 0);

    // T4: FIXED, 40 bytes -> 5 beats, address held
    a0 = ar_addr_q.size(); w0 = wr_q.size(); d0 = done_cnt;
    run_req("t4", 32'h3000, 23'd40, 2'b10, 1'b1, cyc);
    check("t4_ar_count", ar_addr_q.size() - a0, 1);
    check("t4_araddr", ar_addr_q[a0], 32'h3000);
    check("t4_arlen", ar_len_q[a0], 8'd4);
    check("t4_arburst", ar_burst_q[a0], 2'b00);
    check("t4_beats", wr_q.size() - w0, 5);
    check("t4_done", done_cnt - d0, 1);

    // T5: no-op request retires right after LOAD (IDLE, LOAD, RETIRE)
    a0 = ar_addr_q.size(); d0 = done_cnt; e0 = err_cnt;
    run_req("t5", 32'h0100, 23'd64, 2'b00, 1'b1, cyc);
    check("t5_cycles", cyc, 3);
    check("t5_ar_count", ar_addr_q.size() - a0, 0);
    check("t5_done", done_cnt - d0, 1);
    check("t5_err", err_cnt - e0, 0);

    // T6: dataValid=0 also retires OK without reading
    a0 = ar_addr_q.size(); d0 = done_cnt;
    run_req("t6", 32'h0200, 23'd64, 2'b01, 1'b0, cyc);
    check("t6_cycles", cyc, 3);
    check("t6_ar_count", ar_addr_q.size() - a0, 0);
    check("t6_done", done_cnt - d0, 1);

    // T7: reserved srcOp -> rdErr, no AR
    a0 = ar_addr_q.size(); d0 = done_cnt; e0 = err_cnt; c0 = clr_cnt;
    run_req("t7", 32'h0300, 23'd64, 2'b11, 1'b1, cyc);
    check("t7_ar_count", ar_addr_q.size() - a0, 0);
    check("t7_err", err_cnt - e0, 1);
    check("t7_done", done_cnt - d0, 0);
    check("t7_clr", clr_cnt - c0, 1);

    // T8: cacheReady toggling across 8 beats
    w0 = wr_q.size(); base = data_ctr;
    toggle_en = 1'b1;
    run_req("t8", 32'h4000, 23'd64, 2'b01, 1'b1, cyc);
    toggle_en = 1'b0;
    check("t8_beats", wr_q.size() - w0, 8);
    check("t8_order", order_errors(w0, base), 0);

    // T9: address wrap at the top of the 32-bit space
    a0 = ar_addr_q.size(); w0 = wr_q.size(); d0 = done_cnt;
    run_req("t9", 32'hFFFF_FFF8, 23'd16, 2'b01, 1'b1, cyc);
    check("t9_ar_count", ar_addr_q.size() - a0, 2);
    check("t9_araddr0", ar_addr_q[a0], 32'hFFFF_FFF8);
    check("t9_arlen0", ar_len_q[a0], 8'd0);
    check("t9_araddr1", ar_addr_q[a0+1], 32'h0000_0000);
    check("t9_arlen1", ar_len_q[a0+1], 8'd0);
    check("t9_done", done_cnt - d0, 1);

    // T10: SLVERR on beat 3 of 16
    a0 = ar_addr_q.size(); w0 = wr_q.size(); d0 = done_cnt; e0 = err_cnt; c0 = clr_cnt;
    r0 = drain_cnt; base = data_ctr;
    err_beat = beat_no + 2;
    run_req("t10", 32'h5000, 23'd128, 2'b01, 1'b1, cyc);
    err_beat = -1;
    check("t10_ar_count", ar_addr_q.size() - a0, 1);
    check("t10_arlen", ar_len_q[a0], 8'd15);
    check("t10_clr", clr_cnt - c0, 1);
    check("t10_order", order_errors(w0, base), 0);
`ifdef COREAXI4DMA_RD_RRESP_CHK_EN
    check("t10_beats_written", wr_q.size() - w0, 3);
    check("t10_beats_drained", drain_cnt - r0, 13);
    check("t10_err", err_cnt - e0, 1);
    check("t10_done", done_cnt - d0, 0);
`else
    check("t10_beats_written", wr_q.size() - w0, 16);
    check("t10_beats_drained", drain_cnt - r0, 0);
    check("t10_err", err_cnt - e0, 0);
    check("t10_done", done_cnt - d0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
